// File: rtl/riscv_imm_pkg.sv
// Shared definitions for the RISC-V immediate extender/packer pair:
// format codes, rejection codes and per-format immediate limits.
package riscv_imm_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_U = 3'b011,
        FMT_J = 3'b100
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_FMT   = 2'b01,
        ERR_RANGE = 2'b10,
        ERR_ALIGN = 2'b11
    } err_e;

    localparam int signed IMM_I_MIN = -2048;
    localparam int signed IMM_I_MAX = 2047;
    localparam int signed IMM_B_MIN = -4096;
    localparam int signed IMM_B_MAX = 4094;
    localparam int signed IMM_J_MIN = -(1 << 20);
    localparam int signed IMM_J_MAX = (1 << 20) - 2;

endpackage

// File: rtl/instr_imm_packer_if.sv
// Loader-side request bus and instruction-memory write port of the packer.
interface instr_imm_packer_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [31:0]       in_base;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_fmt, in_base, in_imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_fmt, in_base, in_imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imm_field_pack.sv
// Combinational immediate checker/scatterer: merges a signed immediate into
// the I/S/B/U/J fields of a base instruction and flags illegal requests.
module imm_field_pack
    import riscv_imm_pkg::*;
(
    input  logic [2:0]         fmt_i,
    input  logic [31:0]        base_i,
    input  logic signed [31:0] imm_i,
    output logic [31:0]        word_o,
    output logic               ok_o,
    output logic [1:0]         code_o
);

    function automatic logic in_range(input logic signed [31:0] v,
                                      input int signed lo,
                                      input int signed hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Range failures take precedence over alignment failures.
    always_comb begin
        word_o = base_i;
        code_o = ERR_NONE;
        case (fmt_i)
            FMT_I: begin
                word_o[31:20] = imm_i[11:0];
                if (!in_range(imm_i, IMM_I_MIN, IMM_I_MAX)) code_o = ERR_RANGE;
            end
            FMT_S: begin
                word_o[31:25] = imm_i[11:5];
                word_o[11:7]  = imm_i[4:0];
                if (!in_range(imm_i, IMM_I_MIN, IMM_I_MAX)) code_o = ERR_RANGE;
            end
            FMT_B: begin
                word_o[31]    = imm_i[12];
                word_o[30:25] = imm_i[10:5];
                word_o[11:8]  = imm_i[4:1];
                word_o[7]     = imm_i[11];
                if (!in_range(imm_i, IMM_B_MIN, IMM_B_MAX)) code_o = ERR_RANGE;
                else if (imm_i[0])                           code_o = ERR_ALIGN;
            end
            FMT_U: begin
                word_o[31:12] = imm_i[31:12];
                if (imm_i[11:0] != 12'd0) code_o = ERR_ALIGN;
            end
            FMT_J: begin
                word_o[31]    = imm_i[20];
                word_o[30:21] = imm_i[10:1];
                word_o[20]    = imm_i[11];
                word_o[19:12] = imm_i[19:12];
                if (!in_range(imm_i, IMM_J_MIN, IMM_J_MAX)) code_o = ERR_RANGE;
                else if (imm_i[0])                           code_o = ERR_ALIGN;
            end
            default: code_o = ERR_FMT;
        endcase
        ok_o = (code_o == ERR_NONE);
    end

endmodule

// File: rtl/instr_imm_packer.sv
// Sequential immediate encoder: accepts a request, packs it, then writes the
// packed word to instruction memory at an auto-incrementing address.
module instr_imm_packer
    import riscv_imm_pkg::*;
#(
    parameter int              ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    instr_imm_packer_if.slave    bus,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic                 full,
    output logic [ADDR_W:0]      count
);

    typedef enum logic [1:0] {IDLE, PACK, WRITE} state_e;

    state_e             state_q;
    logic               ready_q, we_q, err_q, full_q;
    logic [1:0]         code_q;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [31:0]        wdata_q;

    logic [2:0]         fmt_q;
    logic [31:0]        base_q;
    logic signed [31:0] imm_q;

    logic [31:0]        pack_word;
    logic               pack_ok;
    logic [1:0]         pack_code;
    logic               accept, addr_last;

    assign accept    = (state_q == IDLE) && ready_q && bus.in_valid && !clear;
    assign addr_last = &addr_q;
    // The top address is sticky: it saturates and raises full rather than wrapping.
    assign addr_d    = addr_last ? addr_q : addr_q + 1'b1;
    assign count_d   = count_q + 1'b1;

    // Request payload is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            fmt_q  <= bus.in_fmt;
            base_q <= bus.in_base;
            imm_q  <= bus.in_imm;
        end
    end

    imm_field_pack u_pack (
        .fmt_i  (fmt_q),
        .base_i (base_q),
        .imm_i  (imm_q),
        .word_o (pack_word),
        .ok_o   (pack_ok),
        .code_o (pack_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            wdata_q <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= PACK;
                        ready_q <= 1'b0;
                    end
                end
                PACK: begin
                    if (pack_ok) begin
                        wdata_q <= pack_word;
                        we_q    <= 1'b1;
                        state_q <= WRITE;
                    end else begin
                        err_q   <= 1'b1;
                        code_q  <= pack_code;
                        ready_q <= !full_q;
                        state_q <= IDLE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        we_q    <= 1'b0;
                        addr_q  <= addr_d;
                        count_q <= count_d;
                        full_q  <= addr_last;
                        ready_q <= !addr_last;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign err           = err_q;
    assign err_code      = code_q;
    assign full          = full_q;
    assign count         = count_q;

endmodule
